cc_deserializer: RTL and testbench
==================================

// Module: cc_deserializer
// PURPOSE
//  Receive side of the cache line burst interface. Accepts a wrapping burst of 64b beats
//  (rvalid/rready/rlast) returned by memory for a line fill.
//  Re-assembles the beats into one full 512b cache line and pushes it into the fill FIFO as a
//  518b entry: [517:512] = critical byte offset, [511:0] = line (word w at [64w+63:64w]).
//  Sits between the memory read-data channel and the fill FIFO that feeds the cache data array.
// PARAMETERS
//  DATA_W  64  beat width in bits
//  BEATS   8   beats per line; must be a power of 2
//  OFS_W   6   byte-offset width; word index = ofs[OFS_W-1:OFS_W-$clog2(BEATS)]
// PORTS
//  clk             in   1                      clock, all state on rising edge
//  rst             in   1                      asynchronous, active-high reset
//  ofs_i           in   OFS_W                  critical byte offset of the burst; sampled with beat 0
//  rdata_i         in   DATA_W                 beat data
//  rlast_i         in   1                      last beat of burst
//  rvalid_i        in   1                      beat valid
//  rready_o        out  1                      beat accepted when rvalid_i & rready_o
//  fifo_full_i     in   1                      fill FIFO full
//  fifo_wren_o     out  1                      FIFO push strobe
//  fifo_wdata_o    out  OFS_W+DATA_W*BEATS     {ofs, line} (518b at defaults)
//  err_o           out  1                      1-cycle pulse on rlast protocol error
// BEHAVIOUR
//  Reset (async assert): state=IDLE, beat cnt=0, rready_o=1, fifo_wren_o=0, err_o=0,
//   fifo_wdata_o=0. Partial line in flight is discarded; no push follows.
//  States:
//   IDLE    rready_o=1. On handshake: latch ofs_i, write beat to word W0=ofs_i[5:3],
//           cnt<=1, ->COLLECT (BEATS==1 case not supported).
//   COLLECT rready_o=1. On handshake: write beat to word (W0+cnt) mod BEATS (3b wrap,
//           7->0), cnt<=cnt+1.
//     - cnt==BEATS-1 (final beat): ->PUSH. If rlast_i=0, pulse err_o; line is still pushed.
//     - cnt<BEATS-1 & rlast_i=1 (early last): pulse err_o, discard line, cnt<=0, ->IDLE.
//   PUSH    rready_o=0. fifo_wren_o = !fifo_full_i (combinational from state and full).
//           On push: ->IDLE, cnt<=0. Full: hold PUSH, data stable, wren low.
//  fifo_wdata_o is registered and stable from entry to PUSH until the push cycle.
//  Beats are written into the staging register in place, so no shifting is used.
//  Latency: last beat accepted on cycle N -> fifo_wren_o=1 on cycle N+1 when not full.
//  Throughput: one line per BEATS+1 cycles minimum. No beat is accepted during PUSH.
//  rvalid_i low in IDLE/COLLECT: hold, no state change. Bubbles inside a burst are legal.
//  ofs_i[2:0] (sub-word bits) are carried through unchanged in [517:512]; only bits [5:3]
//   steer placement.
//  err_o is a single-cycle pulse; never asserted together with an accepted beat of a new burst.
// TESTING
//  1 ofs=0x00, beats D0..D7=0x1000+k, rlast on beat 7 -> one push, line word k=0x1000+k,
//    [517:512]=0x00, wren exactly 1 cycle after beat 7.
//  2 ofs=0x10 (word 2), beats B0..B7 -> word (2+k)%8 = Bk; word 1 holds B7; [517:512]=0x10.
//  3 fifo_full_i=1 for 5 cycles after final beat -> wren stays 0, rready_o=0, data stable;
//    push on the first cycle full drops.
//  4 rlast_i on beat 3 -> err_o pulse, no push; next clean burst is pushed correctly.
//  5 8 beats without rlast -> err_o pulse on beat 7, line still pushed.
//    Random rvalid bubbles -> same line content as the no-bubble case.
//  6 rst asserted mid-burst after 4 beats (asynchronously, between edges) -> outputs reset
//    immediately, no push. Next full burst assembles correctly.

Source files
------------

// File: rtl/cc_deserializer.sv
// Line-fill deserializer: gathers a wrapping burst of beats into one cache line
// and pushes {critical offset, line} into the fill FIFO.
module cc_deserializer #(
   parameter int DATA_W = 64,
   parameter int BEATS  = 8,
   parameter int OFS_W  = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [OFS_W-1:0]              ofs_i,
   input  logic [DATA_W-1:0]             rdata_i,
   input  logic                          rlast_i,
   input  logic                          rvalid_i,
   output logic                          rready_o,
   input  logic                          fifo_full_i,
   output logic                          fifo_wren_o,
   output logic [OFS_W+DATA_W*BEATS-1:0] fifo_wdata_o,
   output logic                          err_o
);

   localparam int IDX_W  = $clog2(BEATS);
   localparam int LINE_W = DATA_W * BEATS;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      PUSH
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [IDX_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   w0_q;
   logic [IDX_W-1:0]   widx;
   logic [OFS_W-1:0]   ofs_q;
   logic [LINE_W-1:0]  line_q;
   logic               hs;
   logic               final_beat;

   // ready is a pure function of state, so the handshake avoids a comb loop
   assign hs         = rvalid_i & (state_q != PUSH);
   assign final_beat = (cnt_q == IDX_W'(BEATS - 1));
   assign widx       = (state_q == IDLE) ? ofs_i[OFS_W-1 -: IDX_W]
                                         : IDX_W'(w0_q + cnt_q);
   assign fifo_wdata_o = {ofs_q, line_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (hs) state_d = COLLECT;
         end
         COLLECT: begin
            if (hs) begin
               if (final_beat)   state_d = PUSH;
               else if (rlast_i) state_d = IDLE;
            end
         end
         PUSH: begin
            if (!fifo_full_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rready_o    = 1'b1;
      fifo_wren_o = 1'b0;
      err_o       = 1'b0;
      unique case (state_q)
         IDLE: ;
         COLLECT: begin
            err_o = rvalid_i & (final_beat ? !rlast_i : rlast_i);
         end
         PUSH: begin
            rready_o    = 1'b0;
            fifo_wren_o = !fifo_full_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         w0_q   <= '0;
         ofs_q  <= '0;
         line_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (hs) begin
                  ofs_q <= ofs_i;
                  w0_q  <= ofs_i[OFS_W-1 -: IDX_W];
                  cnt_q <= IDX_W'(1);
               end
            end
            COLLECT: begin
               if (hs) begin
                  if (final_beat || rlast_i) cnt_q <= '0;
                  else                       cnt_q <= cnt_q + IDX_W'(1);
               end
            end
            PUSH: begin
               if (!fifo_full_i) cnt_q <= '0;
            end
            default: cnt_q <= '0;
         endcase
         // beats land directly in their wrapped word slot
         if (hs) begin
            for (int w = 0; w < BEATS; w++) begin
               if (widx == IDX_W'(w)) line_q[w*DATA_W +: DATA_W] <= rdata_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_cc_deserializer.sv
// Bench for cc_deserializer: directed bursts plus random bursts, checked
// against a word-array model of the wrapped line fill.
module tb_cc_deserializer;

   localparam int DW = 64;
   localparam int NB = 8;
   localparam int OW = 6;
   localparam int FW = OW + DW * NB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [OW-1:0] ofs = '0;
   logic [DW-1:0] rdata = '0;
   logic          rlast = 1'b0;
   logic          rvalid = 1'b0;
   logic          rready;
   logic          fifo_full = 1'b0;
   logic          fifo_wren;
   logic [FW-1:0] fifo_wdata;
   logic          err;

   int checks = 0;
   int failures = 0;

   cc_deserializer #(.DATA_W(DW), .BEATS(NB), .OFS_W(OW)) dut (
      .clk          (clk),
      .rst          (rst),
      .ofs_i        (ofs),
      .rdata_i      (rdata),
      .rlast_i      (rlast),
      .rvalid_i     (rvalid),
      .rready_o     (rready),
      .fifo_full_i  (fifo_full),
      .fifo_wren_o  (fifo_wren),
      .fifo_wdata_o (fifo_wdata),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [FW-1:0] obs,
                        input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // last_at: beat index carrying rlast (-1 = never); index 1..6 is an early last
   task automatic run_burst(input logic [OW-1:0] bofs, input int last_at,
                            input bit rnd, input logic [DW-1:0] base,
                            input bit bubbles, input int full_cycles);
      logic [DW-1:0] words [NB];
      logic [DW-1:0] beat;
      logic [FW-1:0] exp_line;
      bit            early;
      int            nbeats;
      int            slot;
      early  = (last_at >= 1) && (last_at < NB - 1);
      nbeats = early ? last_at + 1 : NB;
      for (int w = 0; w < NB; w++) words[w] = '0;
      for (int k = 0; k < nbeats; k++) begin
         if (bubbles) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               rvalid = 1'b0;
               rlast  = 1'b0;
               ofs    = OW'($urandom);
               #1;
               check("bubble_err", FW'(err), FW'(0));
               check("bubble_rdy", FW'(rready), FW'(1));
            end
         end
         beat = rnd ? {$urandom, $urandom} : base + DW'(k);
         @(negedge clk);
         rvalid = 1'b1;
         rdata  = beat;
         rlast  = (k == last_at);
         ofs    = (k == 0) ? bofs : OW'($urandom);
         #1;
         check("beat_rdy", FW'(rready), FW'(1));
         check("beat_wren", FW'(fifo_wren), FW'(0));
         if (k == NB - 1)
            check("beat_err", FW'(err), FW'(last_at != NB - 1));
         else
            check("beat_err", FW'(err), FW'(k == last_at && k > 0));
         slot = (int'(bofs) / (1 << (OW - 3)) + k) % NB;
         words[slot] = beat;
      end
      exp_line = '0;
      exp_line[FW-1 -: OW] = bofs;
      for (int w = 0; w < NB; w++) exp_line[w*DW +: DW] = words[w];
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
      if (early) begin
         #1;
         check("early_wren", FW'(fifo_wren), FW'(0));
         check("early_err", FW'(err), FW'(0));
         check("early_rdy", FW'(rready), FW'(1));
      end else begin
         for (int f = 0; f < full_cycles; f++) begin
            fifo_full = 1'b1;
            #1;
            check("full_wren", FW'(fifo_wren), FW'(0));
            check("full_rdy", FW'(rready), FW'(0));
            check("full_data", fifo_wdata, exp_line);
            @(negedge clk);
         end
         fifo_full = 1'b0;
         #1;
         check("push_wren", FW'(fifo_wren), FW'(1));
         check("push_rdy", FW'(rready), FW'(0));
         check("push_data", fifo_wdata, exp_line);
      end
   endtask

   initial begin
      logic [DW-1:0] b5;
      #3;
      check("rst_rdy", FW'(rready), FW'(1));
      check("rst_wren", FW'(fifo_wren), FW'(0));
      check("rst_err", FW'(err), FW'(0));
      check("rst_data", fifo_wdata, FW'(0));
      @(negedge clk);
      rst = 1'b0;

      run_burst(6'h00, 7, 1'b0, 64'h1000, 1'b0, 0);
      run_burst(6'h10, 7, 1'b0, 64'hB0B0_0000_0000_0000, 1'b0, 0);
      run_burst(6'h2d, 7, 1'b1, '0, 1'b0, 5);
      run_burst(6'h18, 3, 1'b1, '0, 1'b0, 0);
      run_burst(6'h08, 7, 1'b0, 64'h2000, 1'b0, 0);
      run_burst(6'h3f, -1, 1'b1, '0, 1'b0, 0);
      b5 = {$urandom, $urandom};
      run_burst(6'h08, 7, 1'b0, b5, 1'b0, 0);
      run_burst(6'h08, 7, 1'b0, b5, 1'b1, 0);

      // async reset mid-burst after four beats
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rvalid = 1'b1;
         rdata  = {$urandom, $urandom};
         rlast  = 1'b0;
         ofs    = 6'h28;
      end
      @(negedge clk);
      rvalid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_rdy", FW'(rready), FW'(1));
      check("arst_wren", FW'(fifo_wren), FW'(0));
      check("arst_err", FW'(err), FW'(0));
      check("arst_data", fifo_wdata, FW'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         check("arst_nopush", FW'(fifo_wren), FW'(0));
      end
      run_burst(6'h28, 7, 1'b1, '0, 1'b0, 0);

      for (int i = 0; i < 24; i++) begin
         int sel;
         int la;
         sel = int'($urandom_range(0, 5));
         la  = (sel == 0) ? int'($urandom_range(1, 6)) : (sel == 1) ? -1 : 7;
         run_burst(OW'($urandom), la, 1'b1, '0, 1'($urandom),
                   int'($urandom_range(0, 3)));
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
